// File: rtl/loom_dpi_pkg.sv
// Shared types and width helpers for the DPI bridge and the DPI register file.
package loom_dpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALL = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dpi_bridge_state_e;

  localparam int DPI_RET_SCALAR_W = 64;

  // Return channel layout: [63:0] scalar result, then one 32-bit word per argument.
  function automatic int dpi_ret_w(input int max_args);
    return DPI_RET_SCALAR_W + 32 * max_args;
  endfunction

endpackage

// File: rtl/loom_dpi_bridge_if.sv
// Request/response, call/return and status signals of one DPI bridge slot.
// Signal suffixes are from the bridge's point of view; master is the bridge side.
interface loom_dpi_bridge_if
  import loom_dpi_pkg::*;
#(
  parameter int MAX_ARGS = 8
);

  localparam int RET_W = dpi_ret_w(MAX_ARGS);

  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [MAX_ARGS-1:0][31:0] req_args_i;

  logic                      resp_valid_o;
  logic                      resp_ready_i;
  logic [63:0]               resp_result_o;
  logic [MAX_ARGS-1:0][31:0] resp_args_o;

  logic                      call_valid_o;
  logic                      call_ready_i;
  logic [MAX_ARGS-1:0][31:0] call_args_o;

  logic                      ret_valid_i;
  logic                      ret_ready_o;
  logic [RET_W-1:0]          ret_data_i;

  logic                      busy_o;
  logic                      timeout_o;
  logic [31:0]               n_calls_o;

  modport master (
    input  req_valid_i, req_args_i, resp_ready_i, call_ready_i, ret_valid_i, ret_data_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_args_o, call_valid_o,
           call_args_o, ret_ready_o, busy_o, timeout_o, n_calls_o
  );

  modport slave (
    output req_valid_i, req_args_i, resp_ready_i, call_ready_i, ret_valid_i, ret_data_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_args_o, call_valid_o,
           call_args_o, ret_ready_o, busy_o, timeout_o, n_calls_o
  );

endinterface

// File: rtl/loom_dpi_bridge.sv
// DUT-side initiator for one DPI function: forwards a call to the register file
// slot, waits for the host return and hands the result back to the DUT.
//
// state   | meaning
// IDLE    | ready for a DUT request
// CALL    | latched args presented on the call channel
// WAIT    | waiting for the host return, wait counter running
// RESP    | result held for the DUT until consumed
module loom_dpi_bridge
  import loom_dpi_pkg::*;
#(
  parameter int MAX_ARGS  = 8,
  parameter int N_ARGS    = MAX_ARGS,
  parameter int TIMEOUT_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  loom_dpi_bridge_if.master  bus
);

  localparam int RET_W = dpi_ret_w(MAX_ARGS);
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  dpi_bridge_state_e         state_q, state_d;
  logic [MAX_ARGS-1:0][31:0] args_q, args_d;
  logic [63:0]               result_q, result_d;
  logic [MAX_ARGS-1:0][31:0] rargs_q, rargs_d;
  logic [TIMEOUT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                      timeout_q, timeout_d;
  logic [31:0]               n_calls_q, n_calls_d;

  logic req_ready, call_valid, ret_ready, resp_valid;
  logic call_fire, ret_fire;

  always_comb begin
    state_d    = state_q;
    args_d     = args_q;
    result_d   = result_q;
    rargs_d    = rargs_q;
    req_ready  = 1'b0;
    call_valid = 1'b0;
    ret_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) begin
          for (int i = 0; i < MAX_ARGS; i++) begin
            args_d[i] = (i < N_ARGS) ? bus.req_args_i[i] : 32'h0;
          end
          state_d = ST_CALL;
        end
      end
      ST_CALL: begin
        call_valid = 1'b1;
        if (bus.call_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ret_ready = 1'b1;
        if (bus.ret_valid_i) begin
          result_d = bus.ret_data_i[DPI_RET_SCALAR_W-1:0];
          rargs_d  = bus.ret_data_i[RET_W-1:DPI_RET_SCALAR_W];
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      args_q   <= '0;
      result_q <= '0;
      rargs_q  <= '0;
    end else begin
      state_q  <= state_d;
      args_q   <= args_d;
      result_q <= result_d;
      rargs_q  <= rargs_d;
    end
  end

  assign call_fire = (state_q == ST_CALL) && bus.call_ready_i;
  assign ret_fire  = (state_q == ST_WAIT) && bus.ret_valid_i;

  // A return arriving on the would-be saturating cycle stops the count, so it never trips timeout.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (call_fire) begin
      wait_cnt_d = '0;
    end else if ((state_q == ST_WAIT) && !ret_fire && !(&wait_cnt_q)) begin
      wait_cnt_d = wait_cnt_q + WAIT_ONE;
    end
    timeout_d = timeout_q | (&wait_cnt_d);
    n_calls_d = call_fire ? n_calls_q + 32'd1 : n_calls_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) n_calls_q <= '0;
    else       n_calls_q <= n_calls_d;
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.call_valid_o  = call_valid;
  assign bus.ret_ready_o   = ret_ready;
  assign bus.resp_valid_o  = resp_valid;
  assign bus.call_args_o   = args_q;
  assign bus.resp_result_o = result_q;
  assign bus.resp_args_o   = rargs_q;
  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.timeout_o     = timeout_q;
  assign bus.n_calls_o     = n_calls_q;

endmodule

// File: tb/tb_loom_dpi_bridge.sv
// Directed bench for loom_dpi_bridge with N_ARGS=2 and a 4-bit wait counter.
module tb_loom_dpi_bridge;
  import loom_dpi_pkg::*;

  localparam int MA = 8;
  localparam int RW = dpi_ret_w(MA);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lat;

  always #5 clk_i = ~clk_i;

  loom_dpi_bridge_if #(.MAX_ARGS(MA)) bus ();

  loom_dpi_bridge #(.MAX_ARGS(MA), .N_ARGS(2), .TIMEOUT_W(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [RW-1:0] mk_ret(input logic [63:0] res, input logic [31:0] a0,
                                           input logic [31:0] a1);
    logic [RW-1:0] r;
    r = '0;
    r[63:0]   = res;
    r[95:64]  = a0;
    r[127:96] = a1;
    return r;
  endfunction

  // Zero-wait call: everything ready; returns cycles from request edge to resp_valid.
  task automatic run_call(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [RW-1:0] ret, output int l);
    bit done;
    bus.req_args_i[0] = a0;
    bus.req_args_i[1] = a1;
    for (int i = 2; i < MA; i++) bus.req_args_i[i] = 32'hAA00_0000 | i;
    bus.ret_data_i   = ret;
    bus.req_valid_i  = 1'b1;
    bus.call_ready_i = 1'b1;
    bus.ret_valid_i  = 1'b1;
    l = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      l++;
      if (l == 1) begin
        bus.req_valid_i = 1'b0;
        chk("call_valid", {63'd0, bus.call_valid_o}, 64'd1);
        chk("call_arg0", {32'd0, bus.call_args_o[0]}, {32'd0, a0});
        chk("call_arg1", {32'd0, bus.call_args_o[1]}, {32'd0, a1});
        chk("call_arg2_zero", {32'd0, bus.call_args_o[2]}, 64'd0);
        chk("call_arg7_zero", {32'd0, bus.call_args_o[7]}, 64'd0);
        chk("ret_ready_in_call", {63'd0, bus.ret_ready_o}, 64'd0);
      end
      if (bus.resp_valid_o) done = 1'b1;
    end
    bus.ret_valid_i  = 1'b0;
    bus.call_ready_i = 1'b0;
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_args_i   = '0;
    bus.resp_ready_i = 1'b0;
    bus.call_ready_i = 1'b0;
    bus.ret_valid_i  = 1'b0;
    bus.ret_data_i   = '0;
    step();
    step();
    chk("rst_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("rst_call_valid", {63'd0, bus.call_valid_o}, 64'd0);
    chk("rst_ret_ready", {63'd0, bus.ret_ready_o}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.resp_valid_o}, 64'd0);
    chk("rst_timeout", {63'd0, bus.timeout_o}, 64'd0);
    chk("rst_n_calls", {32'd0, bus.n_calls_o}, 64'd0);
    rst_i = 1'b0;
    step();

    // Basic call with output args
    run_call(32'h11, 32'h22, mk_ret(64'hDEAD_BEEF_0000_0001, 32'hCAFE_F00D, 32'h1234_5678), lat);
    chk("latency", lat, 3);
    chk("resp_result", bus.resp_result_o, 64'hDEAD_BEEF_0000_0001);
    chk("resp_arg0", {32'd0, bus.resp_args_o[0]}, 64'hCAFE_F00D);
    chk("resp_arg1", {32'd0, bus.resp_args_o[1]}, 64'h1234_5678);
    chk("n_calls_1", {32'd0, bus.n_calls_o}, 64'd1);
    chk("busy_resp", {63'd0, bus.busy_o}, 64'd1);
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    chk("idle_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    chk("idle_resp_valid", {63'd0, bus.resp_valid_o}, 64'd0);
    chk("idle_busy", {63'd0, bus.busy_o}, 64'd0);

    // Back-pressure on call and response channels
    bus.req_args_i[0] = 32'h33;
    bus.req_args_i[1] = 32'h44;
    bus.req_args_i[2] = 32'h55;
    bus.req_valid_i   = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.req_args_i[0] = 32'hBAD0_0000 | i;
      step();
      chk("bp_call_valid", {63'd0, bus.call_valid_o}, 64'd1);
      chk("bp_call_arg0", {32'd0, bus.call_args_o[0]}, 64'h33);
      chk("bp_call_arg2", {32'd0, bus.call_args_o[2]}, 64'd0);
      chk("bp_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
    end
    bus.call_ready_i = 1'b1;
    step();
    bus.call_ready_i = 1'b0;
    chk("bp_wait_ret_ready", {63'd0, bus.ret_ready_o}, 64'd1);
    chk("n_calls_2", {32'd0, bus.n_calls_o}, 64'd2);
    bus.ret_data_i  = mk_ret(64'h0123_4567_89AB_CDEF, 32'h5555, 32'h6666);
    bus.ret_valid_i = 1'b1;
    step();
    bus.ret_valid_i = 1'b0;
    bus.ret_data_i  = mk_ret(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_resp_valid", {63'd0, bus.resp_valid_o}, 64'd1);
      chk("bp_resp_result", bus.resp_result_o, 64'h0123_4567_89AB_CDEF);
      chk("bp_resp_arg0", {32'd0, bus.resp_args_o[0]}, 64'h5555);
      chk("bp_resp_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
    end
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    chk("bp_back_idle", {63'd0, bus.busy_o}, 64'd0);

    // Return on the cycle the counter would saturate: no timeout
    bus.req_valid_i  = 1'b1;
    bus.call_ready_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    step();
    bus.call_ready_i = 1'b0;
    repeat (14) step();
    chk("tie_still_wait", {63'd0, bus.ret_ready_o}, 64'd1);
    chk("tie_pre_timeout", {63'd0, bus.timeout_o}, 64'd0);
    bus.ret_data_i  = mk_ret(64'h0F0F, 32'h1, 32'h2);
    bus.ret_valid_i = 1'b1;
    step();
    bus.ret_valid_i = 1'b0;
    chk("tie_resp_valid", {63'd0, bus.resp_valid_o}, 64'd1);
    chk("tie_timeout", {63'd0, bus.timeout_o}, 64'd0);
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    chk("tie_timeout_idle", {63'd0, bus.timeout_o}, 64'd0);
    chk("n_calls_3", {32'd0, bus.n_calls_o}, 64'd3);

    // Timeout after 15 empty wait cycles; the wait continues
    bus.req_valid_i  = 1'b1;
    bus.call_ready_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    step();
    bus.call_ready_i = 1'b0;
    repeat (14) step();
    chk("to_before", {63'd0, bus.timeout_o}, 64'd0);
    step();
    chk("to_set", {63'd0, bus.timeout_o}, 64'd1);
    repeat (5) step();
    chk("to_still_wait", {63'd0, bus.ret_ready_o}, 64'd1);
    bus.ret_data_i  = mk_ret(64'hFEED_FACE_0000_0042, 32'h9, 32'h0);
    bus.ret_valid_i = 1'b1;
    step();
    bus.ret_valid_i = 1'b0;
    chk("to_resp_valid", {63'd0, bus.resp_valid_o}, 64'd1);
    chk("to_resp_result", bus.resp_result_o, 64'hFEED_FACE_0000_0042);
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    chk("to_sticky_idle", {63'd0, bus.timeout_o}, 64'd1);
    chk("n_calls_4", {32'd0, bus.n_calls_o}, 64'd4);

    // Reset while waiting for the return
    bus.req_valid_i  = 1'b1;
    bus.call_ready_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    step();
    bus.call_ready_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mr_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    chk("mr_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("mr_ret_ready", {63'd0, bus.ret_ready_o}, 64'd0);
    chk("mr_n_calls", {32'd0, bus.n_calls_o}, 64'd0);
    chk("mr_timeout", {63'd0, bus.timeout_o}, 64'd0);
    chk("mr_call_arg0", {32'd0, bus.call_args_o[0]}, 64'd0);
    chk("mr_resp_result", bus.resp_result_o, 64'd0);
    run_call(32'h77, 32'h88, mk_ret(64'h0000_0000_0000_0001, 32'hABCD, 32'h0), lat);
    chk("mr_latency", lat, 3);
    chk("mr_resp_result2", bus.resp_result_o, 64'h1);
    chk("mr_resp_arg0", {32'd0, bus.resp_args_o[0]}, 64'hABCD);
    chk("mr_n_calls_1", {32'd0, bus.n_calls_o}, 64'd1);
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    chk("mr_final_idle", {63'd0, bus.req_ready_o}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
